// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan driver.
// Holds the active-low segment table, blank/off codes and the shadow bundle.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low gfedcba patterns, index = hex code.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    PH_BLANK  = 1'b0,
    PH_ACTIVE = 1'b1
  } phase_e;

  typedef struct packed {
    logic [3:0] code;
    logic       en;
    logic       dp;
  } shadow_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex code to active-low segment pattern.
// Ports: code_i (4-bit hex code), seg_o (7-bit gfedcba, active-low).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for an 8-digit common-anode display.
// Ports: clk, rst_n, digits/digit_en/dp in; AN, seg, dp_n, frame_done out.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  output logic [7:0]  AN,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  shadow_t       sh_q, sh_d;

  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dpn_q, dpn_d;
  logic       fd_q, fd_d;

  logic       slot_end;
  logic       slot_start;
  shadow_t    live;
  phase_e     phase;
  logic [6:0] dec_seg;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign slot_start = (cnt_q == '0);

  assign live.code = digits[{idx_q, 2'b00} +: 4];
  assign live.en   = digit_en[idx_q];
  assign live.dp   = dp[idx_q];

  assign phase = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_ACTIVE;

  // State register: divider, digit index and per-slot shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

  // Next state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d  = sh_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end
    if (slot_start) begin
      sh_d = live;
    end
  end

  // sh_d is the slot's latched value already at cnt==0, so a zero-length
  // blank window still shows this slot's digit, not the previous one.
  seg7_decode u_decode (
    .code_i (sh_d.code),
    .seg_o  (dec_seg)
  );

  // Output next values; idx never reaches NUM_DIGITS, so higher AN bits stay 1.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dpn_d = 1'b1;
    fd_d  = slot_end && (idx_q == IDX_LAST);
    unique case (1'b1)
      (phase == PH_ACTIVE) && sh_d.en: begin
        an_d  = AN_OFF & ~(8'h01 << idx_q);
        seg_d = dec_seg;
        dpn_d = ~sh_d.dp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dpn_q <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      fd_q  <= fd_d;
    end
  end

  assign AN         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dpn_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: randomized self-checking bench for seg7_scan_mux.
// Reference model derives outputs from edge count and input history.
module tb_seg7_scan_mux;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int ND    = 8;
  localparam int HMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  AN;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .CLK_HZ     (80),
    .REFRESH_HZ (10),
    .NUM_DIGITS (8),
    .BLANK_CYC  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp         (dp),
    .AN         (AN),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [16:0] BLANK_VEC = {8'hFF, 7'h7F, 1'b1, 1'b0};

  int checks = 0;
  int errors = 0;
  int n;
  int cur_i, cur_c;
  logic [31:0] h_d [HMAX];
  logic [7:0]  h_e [HMAX];
  logic [7:0]  h_p [HMAX];
  logic [16:0] got, want;

  assign got = {AN, seg, dp_n, frame_done};

  // One clock after release edge count n: pins show the scan position
  // k = n-1; a slot shows the inputs present when it began.
  task automatic tick();
    int k, k0;
    logic [31:0] d;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dpn, e_fd;
    h_d[n] = digits;
    h_e[n] = digit_en;
    h_p[n] = dp;
    @(posedge clk);
    n++;
    @(negedge clk);
    k = n - 1;
    cur_c = k % DIV;
    cur_i = (k / DIV) % ND;
    k0 = k - cur_c;
    e_an = 8'hFF;
    e_seg = 7'h7F;
    e_dpn = 1'b1;
    e_fd = (cur_c == DIV - 1) && (cur_i == ND - 1);
    if (cur_c >= BLANK && h_e[k0][cur_i]) begin
      d = h_d[k0];
      e_an = ~(8'd1 << cur_i);
      e_seg = SEG_REF[d[4*cur_i +: 4]];
      e_dpn = ~h_p[k0][cur_i];
    end
    want = {e_an, e_seg, e_dpn, e_fd};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    digits = 32'h76543210;
    digit_en = 8'hFF;
    dp = 8'h00;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (got !== BLANK_VEC) begin
        errors++;
        $display("FAIL reset: got %h want %h", got, BLANK_VEC);
      end
    end
    n = 0;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_rel n=%0d: got %h want %h", n, got, want);
      end
    end
    checks++;
    if (AN !== 8'hFE) begin
      errors++;
      $display("FAIL first_lit: AN=%h want fe", AN);
    end
  endtask

  task automatic test_scan();
    int last_fd = -1;
    int pulses = 0;
    for (int j = 0; j < 128; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scan n=%0d: got %h want %h", n, got, want);
      end
      if (cur_i == 5 && cur_c >= BLANK) begin
        checks++;
        if (seg !== 7'h12 || AN !== 8'hDF) begin
          errors++;
          $display("FAIL digit5: AN=%h seg=%h want df 12", AN, seg);
        end
      end
      if (frame_done) begin
        pulses++;
        if (last_fd >= 0) begin
          checks++;
          if (n - last_fd != 64) begin
            errors++;
            $display("FAIL fd_period: got %0d want 64", n - last_fd);
          end
        end
        last_fd = n;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL fd_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_digit_en();
    digit_en = 8'b1111_1011;
    for (int j = 0; j < 128; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL digit_en n=%0d: got %h want %h", n, got, want);
      end
      if (cur_i == 2) begin
        checks++;
        if (AN !== 8'hFF || seg !== 7'h7F) begin
          errors++;
          $display("FAIL blank_slot2: AN=%h seg=%h want ff 7f", AN, seg);
        end
      end
    end
  endtask

  task automatic test_dp();
    digits[3:0] = 4'h9;
    dp = 8'h01;
    for (int j = 0; j < 128; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL dp n=%0d: got %h want %h", n, got, want);
      end
      if (j >= 64) begin
        if (cur_i == 0 && cur_c >= BLANK) begin
          checks++;
          if (seg !== 7'h10 || dp_n !== 1'b0) begin
            errors++;
            $display("FAIL dp0: seg=%h dp_n=%b want 10 0", seg, dp_n);
          end
        end else if (cur_i != 0) begin
          checks++;
          if (dp_n !== 1'b1) begin
            errors++;
            $display("FAIL dp_other: dp_n=%b want 1", dp_n);
          end
        end
      end
    end
  endtask

  task automatic test_midslot();
    digits[3:0] = 4'h5;
    tick();
    while (n % 64 != 0) tick();
    while (n % 64 != 4) tick();
    digits[3:0] = 4'h9;
    for (int j = 0; j < 68; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL midslot n=%0d: got %h want %h", n, got, want);
      end
      if (cur_i == 0 && cur_c >= BLANK) begin
        checks++;
        if (seg !== ((j < 4) ? 7'h12 : 7'h10)) begin
          errors++;
          $display("FAIL midslot_seg j=%0d: seg=%h", j, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits = $urandom;
        digit_en = 8'($urandom);
        dp = 8'($urandom);
      end
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random n=%0d: got %h want %h", n, got, want);
      end
    end
  endtask

  task automatic test_reset_midslot();
    int first_fd = -1;
    digit_en = 8'hFF;
    tick();
    while (n % 64 != 0) tick();
    while (n % 64 != 29) tick();
    checks++;
    if (AN !== 8'hF7) begin
      errors++;
      $display("FAIL pre_reset: AN=%h want f7", AN);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== BLANK_VEC) begin
      errors++;
      $display("FAIL async_rst: got %h want %h", got, BLANK_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    n = 0;
    rst_n = 1'b1;
    for (int j = 0; j < 70; j++) begin
      tick();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_mid n=%0d: got %h want %h", n, got, want);
      end
      if (n == 3) begin
        checks++;
        if (AN !== 8'hFE) begin
          errors++;
          $display("FAIL restart_d0: AN=%h want fe", AN);
        end
      end
      if (frame_done && first_fd < 0) first_fd = n;
    end
    checks++;
    if (first_fd != 64) begin
      errors++;
      $display("FAIL first_fd: got %0d want 64", first_fd);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_digit_en();
    test_dp();
    test_midslot();
    test_random();
    test_reset_midslot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed driver for the 8-digit common-anode 7-segment display. It takes eight 4-bit hex digit codes plus per-digit enable and decimal-point bits, and scans one digit at a time at a fixed per-digit refresh rate. It drives active-low anodes and cathodes. It sits directly downstream of the digit sequencers (roll-number, counter displays) and replaces hard-wired single-digit anode driving.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz.
REFRESH_HZ, 1000, digit-slot rate in Hz (full frame rate = REFRESH_HZ/NUM_DIGITS).
NUM_DIGITS, 8, number of digits scanned (1..8); unused AN bits are held at 1.
BLANK_CYC, 64, clocks at the start of each slot with all anodes off (anti-ghosting); must be < DIV.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
digits  input  32  hex codes, digit i = digits[4i+3:4i]; digit 0 is rightmost.
digit_en  input  8  1 = digit i lit, 0 = digit i blank for its whole slot.
dp  input  8  1 = decimal point of digit i lit.
AN  output  8  anodes, active-low, one-hot-low during the active part of a slot.
seg  output  7  cathodes a..g, active-low, seg[0]=a ... seg[6]=g.
dp_n  output  1  decimal-point cathode, active-low.
frame_done  output  1  one-clock pulse when the last digit slot ends.

Behaviour:
- DIV = CLK_HZ/REFRESH_HZ (integer division, compile-time). Slot counter cnt runs 0..DIV-1 and wraps to 0.
- Digit index idx runs 0..NUM_DIGITS-1. It advances when cnt == DIV-1 and wraps NUM_DIGITS-1 -> 0.
- frame_done = 1 for exactly the clock in which cnt == DIV-1 and idx == NUM_DIGITS-1. It is registered, so it is visible in the following cycle.
- When cnt == 0, the slot latches digits[idx], digit_en[idx] and dp[idx] into shadow registers. Input changes mid-slot have no effect until the next slot of that digit.
- Blank window, cnt < BLANK_CYC: AN = 8'hFF, seg = 7'h7F, dp_n = 1.
- Active window, cnt >= BLANK_CYC:
  - If the shadow enable is 1: AN[idx] = 0 and all other AN bits = 1; seg = decoded shadow code; dp_n = ~shadow dp.
  - If the shadow enable is 0: outputs are as in the blank window.
- All outputs are registered, giving one clock of latency from the cnt/idx state to the pins. There are no combinational paths from inputs to outputs.
- Decode table, active-low gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Reset (asynchronous assert, synchronous release by design): cnt=0, idx=0, shadows=0, AN=8'hFF, seg=7'h7F, dp_n=1, frame_done=0. Reset mid-slot blanks the display on the next edge and restarts scanning at digit 0 with a full blank window.
- AN bits at index >= NUM_DIGITS are always 1.
- No handshake: inputs are level-sampled once per slot.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-low segment constant table;
  - localparams SEG_BLANK=7'h7F and AN_OFF=8'hFF.
- One sub-module: seg7_decode. It is combinational, maps 4-bit code -> 7-bit active-low segments from the package table, and is instantiated once on the shadow code.
- Divider and scan FSM stay in the top module.

Test Plan (CLK_HZ=80, REFRESH_HZ=10 -> DIV=8, BLANK_CYC=2, NUM_DIGITS=8):
1. Hold rst_n=0 for 5 clks, then release -> AN=FF, seg=7F, dp_n=1, frame_done=0 throughout reset. First lit output is AN=FE at cycle 3 after release (blank cycles 0-1 plus 1 register delay).
2. Drive digits=32'h76543210, digit_en=FF, dp=00 -> the slot for digit i shows AN with bit i low and seg = table[i]. Check digit 5 -> seg=12. Check frame_done pulses every 64 clks.
3. Drive digit_en=8'b1111_1011 -> AN stays FF and seg=7F for the entire slot of digit 2. Other digits are unaffected.
4. Drive dp=8'h01 with digits[3:0]=4'h9 -> slot 0 shows seg=10 and dp_n=0. All other slots show dp_n=1.
5. Change digits[3:0] from 5 to 9 at cnt=4 of slot 0 -> slot 0 shows seg=12 to the end of the slot. The next frame's slot 0 shows seg=10.
6. Assert rst_n=0 at cnt=5 of slot 3 -> outputs are blank immediately (asynchronous). After release, scanning restarts at digit 0 and frame_done is first seen 64 clks later.
